// File: rtl/elementwise_alu_pipe.sv
// rtl/elementwise_alu_pipe.sv - lane-serial elementwise MUL/MAC/ADD/SUB over N-element vectors
module elementwise_alu_pipe #(
  parameter int W      = 8,
  parameter int N      = 16,
  parameter int LANES  = 4,
  parameter int SIGNED = 0
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic [1:0]         i_mode,
  input  logic [N*W-1:0]     i_mtx_u,
  input  logic [N*W-1:0]     i_mtx_v,
  output logic               o_valid,
  input  logic               i_ready,
  output logic [N*2*W-1:0]   o_mtx_m,
  output logic               o_busy
);

  localparam int BEATS = N / LANES;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [1:0] MODE_MUL = 2'd0;
  localparam logic [1:0] MODE_MAC = 2'd1;
  localparam logic [1:0] MODE_ADD = 2'd2;
  localparam logic [1:0] MODE_SUB = 2'd3;

  logic [1:0]         state;
  logic [BW-1:0]      beat;
  logic [N*W-1:0]     u_q;
  logic [N*W-1:0]     v_q;
  logic [1:0]         mode_q;
  logic [N*2*W-1:0]   m_q;
  logic [2*W-1:0]     lane_res [LANES];

  function automatic logic [2*W-1:0] ext(input logic [W-1:0] x);
    if (SIGNED != 0) return {{W{x[W-1]}}, x};
    else             return {{W{1'b0}}, x};
  endfunction

  // Products of the 2W-bit extended operands truncated to 2W are exact in both signednesses.
  function automatic logic [2*W-1:0] lane_op(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic [2*W-1:0] prev, input logic [1:0] mode);
    logic [2*W-1:0] r;
    case (mode)
      MODE_MUL: r = ext(a) * ext(b);
      MODE_MAC: r = prev + ext(a) * ext(b);
      MODE_ADD: r = ext(a) + ext(b);
      MODE_SUB: r = ext(a) - ext(b);
      default:  r = '0;
    endcase
    return r;
  endfunction

  always_comb begin
    int idx;
    idx = 0;
    for (int l = 0; l < LANES; l++) begin
      idx = int'(beat) * LANES + l;
      lane_res[l] = lane_op(u_q[idx*W +: W], v_q[idx*W +: W], m_q[idx*2*W +: 2*W], mode_q);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state  <= S_IDLE;
      beat   <= '0;
      u_q    <= '0;
      v_q    <= '0;
      mode_q <= '0;
      m_q    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (i_valid) begin
            u_q    <= i_mtx_u;
            v_q    <= i_mtx_v;
            mode_q <= i_mode;
            beat   <= '0;
            state  <= S_RUN;
          end
        end
        S_RUN: begin
          for (int l = 0; l < LANES; l++) begin
            m_q[(int'(beat) * LANES + l)*2*W +: 2*W] <= lane_res[l];
          end
          beat <= beat + 1'b1;
          if (beat == BW'(BEATS - 1)) state <= S_DONE;
        end
        S_DONE: begin
          if (i_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign o_ready = (state == S_IDLE);
  assign o_busy  = (state == S_RUN);
  assign o_valid = (state == S_DONE);
  assign o_mtx_m = m_q;

endmodule

// File: doc/elementwise_alu_pipe.md
Name: elementwise_alu_pipe

Overview:
- Parametrised, lane-serial successor to the 4x4 elementwise multiplier.
- Accepts two N-element operand vectors through a valid/ready handshake. Processes LANES elements per cycle using a selectable operation: multiply, multiply-accumulate, add or subtract.
- Holds the N-element 2W-bit result until downstream accepts it.
- Sits between the operand register file and the result writeback stage of the datapath controller.

Parameters:
- W, 8, operand element width in bits; each result element is 2*W bits.
- N, 16, elements per vector (16 = 4x4 matrix); N must be a multiple of LANES.
- LANES, 4, elements processed per cycle (number of multipliers/adders instantiated).
- SIGNED, 0, 0 = unsigned operands; 1 = two's-complement operands.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rstn  input  1  asynchronous, active-low reset.
- i_valid  input  1  operand vectors and mode are valid.
- o_ready  output  1  block can accept operands; high exactly when the FSM is in IDLE.
- i_mode  input  2  00 MUL, 01 MAC, 10 ADD, 11 SUB; sampled only on accept.
- i_mtx_u  input  N*W  operand U; element i at bits [i*W +: W].
- i_mtx_v  input  N*W  operand V; same packing as U.
- o_valid  output  1  result vector valid.
- i_ready  input  1  downstream accepts the result.
- o_mtx_m  output  N*2*W  result vector; element i at bits [i*2W +: 2W].
- o_busy  output  1  high in RUN.

Behaviour:
- Reset (async, rstn=0):
  - state = IDLE, beat counter = 0, o_valid = 0, o_busy = 0.
  - o_mtx_m = 0, operand and mode registers = 0.
  - o_ready = 1 once in IDLE.
  - Reset asserted mid-RUN or mid-DONE aborts the operation; the result is cleared to 0.
- FSM states:
  - IDLE -> RUN on accept (i_valid & o_ready). At accept, i_mtx_u, i_mtx_v and i_mode are captured into internal registers and the beat counter is cleared. Later input changes have no effect.
  - RUN: BEATS = N/LANES cycles. On beat k, elements k*LANES .. k*LANES+LANES-1 are computed from the captured operands and written into their o_mtx_m slots. The counter increments each beat. After beat BEATS-1 the FSM goes to DONE.
  - DONE: o_valid = 1, o_mtx_m stable. On i_valid... no: on o_valid & i_ready the FSM goes to IDLE.
  - No new operands are accepted in the same cycle as the result handshake; there is exactly one IDLE cycle between jobs.
- Latency:
  - o_valid rises BEATS cycles after the accept edge (4 cycles for N=16, LANES=4).
  - Minimum throughput is one job per BEATS+2 cycles.
- Arithmetic (per element i, all results modulo 2^(2W)):
  - Each operand is extended to 2W bits: zero-extended if SIGNED=0, sign-extended if SIGNED=1.
  - MUL: m[i] = u[i]*v[i]. This is the full 2W product, exact in both signednesses.
  - MAC: m[i] = m_prev[i] + u[i]*v[i], where m_prev is the value held in o_mtx_m from the previous job. Overflow wraps and no saturation is applied. MAC immediately after reset accumulates onto 0.
  - ADD: m[i] = ext(u[i]) + ext(v[i]).
  - SUB: m[i] = ext(u[i]) - ext(v[i]); the result wraps (unsigned 0-1 = 2^(2W)-1).
- o_mtx_m contents during RUN are partially updated and not guaranteed. Consumers use them only while o_valid = 1.
- i_ready high while not in DONE is ignored.
- i_valid high while o_ready = 0 is ignored; the operands are not queued.

Test Plan:
- Reset, then MUL with N=16, LANES=4, SIGNED=0, u[i]=i+1, v[i]=2 -> o_valid exactly 4 cycles after accept; m[i]=2*(i+1); m[15]=32.
- Boundary MUL with u=v=0xFF for all elements, SIGNED=0 -> every m[i]=16'hFE01. Same stimulus with SIGNED=1 -> every m[i]=16'h0001.
- MAC chain:
  - MUL with u=3, v=4 -> m=12.
  - Then MAC with u=5, v=6 -> m=42.
  - Then MAC with u=v=0xFF unsigned, repeated 2 times from 42 -> (42+2*65025) mod 65536 = 64556.
- ADD/SUB: ADD u=0xFF, v=0x01 unsigned -> 16'h0100. SUB u=0x00, v=0x01 unsigned -> 16'hFFFF. SUB with SIGNED=1, u=0x80, v=0x01 -> 16'hFF7F.
- Backpressure: hold i_ready=0 for 10 cycles in DONE -> o_valid stays 1, o_mtx_m unchanged, o_ready=0. A second i_valid pulse during this window is not accepted. Raising i_ready -> one IDLE cycle, then the new job is accepted.
- Mid-operation reset: assert rstn=0 during beat 2 of RUN -> o_valid=0, o_mtx_m=0, o_busy=0 immediately. After release the block is in IDLE with o_ready=1 and the next MUL produces correct results.
